// File: rtl/midi_voice_controller.sv
// MIDI voice controller: parses a received MIDI byte stream (running status, realtime
// interleave, system-common abort) and drives a single monophonic voice.
//
// Parameters:
//   OMNI           - 1: accept every channel; 0: accept only status channel == channel
//   AMPLITUDE_BITS - width of the amplitude output
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   rx_data    - received MIDI byte
//   rx_valid   - one-cycle strobe qualifying rx_data
//   channel    - listening channel (ignored when OMNI=1)
//   midi_data  - current note number, bit 7 always 0
//   amplitude  - note-on velocity, left-justified with MSB replication
//   enable     - gate, high while a note is held
//   note_event - one-cycle pulse when a message changes the voice outputs
module midi_voice_controller #(
   parameter int unsigned OMNI           = 0,
   parameter int unsigned AMPLITUDE_BITS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   input  logic [3:0]                channel,
   output logic [7:0]                midi_data,
   output logic [AMPLITUDE_BITS-1:0] amplitude,
   output logic                      enable,
   output logic                      note_event
);

   typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

   state_e                    state_q, state_d;
   logic [7:0]                status_q, status_d;
   logic [6:0]                d1_q, d1_d;
   logic [6:0]                note_q, note_d;
   logic [AMPLITUDE_BITS-1:0] amp_q, amp_d;
   logic                      en_q, en_d;
   logic                      event_q, event_d;

   logic [AMPLITUDE_BITS-1:0] scaled;
   logic                      chan_match;

   // Velocity in rx_data[6:0] left-justified, its MSBs repeated down into the LSBs.
   always_comb begin
      scaled = '0;
      for (int i = 0; i < int'(AMPLITUDE_BITS); i++) begin
         scaled[i] = rx_data[6 - ((int'(AMPLITUDE_BITS) - 1 - i) % 7)];
      end
   end

   assign chan_match = (OMNI != 0) || (status_q[3:0] == channel);

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      d1_d     = d1_q;
      note_d   = note_q;
      amp_d    = amp_q;
      en_d     = en_q;
      event_d  = 1'b0;

      if (rx_valid) begin
         if (rx_data[7]) begin
            if (rx_data[7:4] != 4'hF) begin
               // Channel voice status: becomes running status, aborts any partial message.
               status_d = rx_data;
               state_d  = StWaitD1;
            end else if (!rx_data[3]) begin
               // System common: running status is lost.
               status_d = '0;
               state_d  = StIdle;
            end
            // Realtime (0xF8-0xFF) falls through untouched.
         end else begin
            unique case (state_q)
               StIdle: state_d = StIdle;
               StWaitD1: begin
                  d1_d = rx_data[6:0];
                  // Program change / channel pressure carry a single data byte.
                  state_d = (status_q[7:5] == 3'b110) ? StWaitD1 : StWaitD2;
               end
               StWaitD2: begin
                  state_d = StWaitD1;
                  if (chan_match) begin
                     if (status_q[7:4] == 4'h9 && rx_data[6:0] != 7'd0) begin
                        note_d  = d1_q;
                        amp_d   = scaled;
                        en_d    = 1'b1;
                        event_d = 1'b1;
                     end else if (status_q[7:4] == 4'h8 || status_q[7:4] == 4'h9) begin
                        if (en_q && d1_q == note_q) begin
                           en_d    = 1'b0;
                           event_d = 1'b1;
                        end
                     end else if (status_q[7:4] == 4'hB && d1_q == 7'd123) begin
                        if (en_q) begin
                           en_d    = 1'b0;
                           event_d = 1'b1;
                        end
                     end
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         status_q <= '0;
         d1_q     <= '0;
         note_q   <= '0;
         amp_q    <= '0;
         en_q     <= 1'b0;
         event_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         d1_q     <= d1_d;
         note_q   <= note_d;
         amp_q    <= amp_d;
         en_q     <= en_d;
         event_q  <= event_d;
      end
   end

   assign midi_data  = {1'b0, note_q};
   assign amplitude  = amp_q;
   assign enable     = en_q;
   assign note_event = event_q;

endmodule

// File: tb/tb_midi_voice_controller.sv
// Bench for midi_voice_controller (OMNI=0, AMPLITUDE_BITS=8): a message-level model
// tracked with a running-status value and a queue of pending data bytes, compared
// against the DUT on every falling edge, plus literal expectations for the named scenarios.
module tb_midi_voice_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [3:0] channel = 4'd0;
   logic [7:0] midi_data;
   logic [7:0] amplitude;
   logic       enable;
   logic       note_event;

   midi_voice_controller #(
      .OMNI          (0),
      .AMPLITUDE_BITS(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .channel   (channel),
      .midi_data (midi_data),
      .amplitude (amplitude),
      .enable    (enable),
      .note_event(note_event)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic running = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- message-level model ----------------
   int m_rs = -1;        // running status byte, -1 when none
   int m_q[$];           // data bytes collected for the current message
   int m_note = 0;
   int m_amp  = 0;
   int m_en   = 0;
   int m_ev   = 0;

   task automatic model_reset();
      m_rs = -1;
      m_q.delete();
      m_note = 0;
      m_amp  = 0;
      m_en   = 0;
      m_ev   = 0;
   endtask

   task automatic model_exec(input int d1, input int d2);
      int kind;
      if ((m_rs & 15) != int'(channel)) return;
      kind = m_rs >> 4;
      if (kind == 9 && d2 != 0) begin
         m_note = d1;
         m_amp  = ((d2 << 1) | (d2 >> 6)) & 255;
         m_en   = 1;
         m_ev   = 1;
      end else if (kind == 8 || kind == 9) begin
         if (m_en == 1 && m_note == d1) begin
            m_en = 0;
            m_ev = 1;
         end
      end else if (kind == 11 && d1 == 123 && m_en == 1) begin
         m_en = 0;
         m_ev = 1;
      end
   endtask

   task automatic model_byte(input int b);
      int need;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         m_rs = -1;
         m_q.delete();
      end else if (b >= 'h80) begin
         m_rs = b;
         m_q.delete();
      end else if (m_rs >= 0) begin
         m_q.push_back(b);
         need = ((m_rs >> 4) == 12 || (m_rs >> 4) == 13) ? 1 : 2;
         if (m_q.size() == need) begin
            if (need == 2) model_exec(m_q[0], m_q[1]);
            m_q.delete();
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            m_ev = 0;
            if (rx_valid) model_byte(int'(rx_data));
         end
      end
   end

   always @(negedge clk) begin
      if (running) begin
         chk("model midi_data", {24'd0, midi_data}, m_note);
         chk("model amplitude", {24'd0, amplitude}, m_amp);
         chk("model enable", {31'd0, enable}, m_en);
         chk("model note_event", {31'd0, note_event}, m_ev);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a);
      send(b);
      send(c);
   endtask

   // Called right after a send: checks the outputs visible after that final byte.
   task automatic expect_out(input string name, input logic [7:0] note, input logic [7:0] amp,
                             input logic en, input logic ev);
      @(negedge clk);
      chk({name, " midi_data"}, {24'd0, midi_data}, {24'd0, note});
      chk({name, " amplitude"}, {24'd0, amplitude}, {24'd0, amp});
      chk({name, " enable"}, {31'd0, enable}, {31'd0, en});
      chk({name, " note_event"}, {31'd0, note_event}, {31'd0, ev});
   endtask

   initial begin
      running = 1'b1;
      repeat (3) @(posedge clk);
      expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Basic note-on, single pulse.
      send3(8'h90, 8'h3C, 8'h64);
      expect_out("note_on", 8'h3C, 8'hC9, 1'b1, 1'b1);
      expect_out("note_on pulse end", 8'h3C, 8'hC9, 1'b1, 1'b0);

      // Running status: retrigger, non-matching off, matching off.
      send(8'h40); send(8'h7F);
      expect_out("rs retrigger", 8'h40, 8'hFF, 1'b1, 1'b1);
      send(8'h3C); send(8'h00);
      expect_out("rs off mismatch", 8'h40, 8'hFF, 1'b1, 1'b0);
      send(8'h40); send(8'h00);
      expect_out("rs off match", 8'h40, 8'hFF, 1'b0, 1'b1);

      // Realtime interleave, then note-off, then system common abort.
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
      expect_out("realtime interleave", 8'h3C, 8'hC9, 1'b1, 1'b1);
      send3(8'h80, 8'h3C, 8'h10);
      expect_out("note_off", 8'h3C, 8'hC9, 1'b0, 1'b1);
      send(8'h90); send(8'h50); send(8'hF0); send(8'h10);
      expect_out("sysex abort", 8'h3C, 8'hC9, 1'b0, 1'b0);
      send(8'h20); send(8'h30);
      expect_out("idle data", 8'h3C, 8'hC9, 1'b0, 1'b0);

      // Channel filtering with channel=2.
      channel = 4'd2;
      send3(8'h91, 8'h3C, 8'h64);
      expect_out("wrong channel", 8'h3C, 8'hC9, 1'b0, 1'b0);
      send3(8'h92, 8'h3C, 8'h64);
      expect_out("right channel", 8'h3C, 8'hC9, 1'b1, 1'b1);
      send3(8'hB2, 8'h7B, 8'h00);
      expect_out("all notes off", 8'h3C, 8'hC9, 1'b0, 1'b1);
      send(8'h7B); send(8'h00);
      expect_out("all off while off", 8'h3C, 8'hC9, 1'b0, 1'b0);
      // One-data-byte program change under running status, then a new note.
      send(8'hC2); send(8'h05); send(8'h06);
      send3(8'h92, 8'h41, 8'h01);
      expect_out("after program", 8'h41, 8'h02, 1'b1, 1'b1);
      // Channel is sampled only when the message completes.
      send(8'h92); send(8'h45);
      channel = 4'd5;
      send(8'h70);
      expect_out("channel at completion", 8'h41, 8'h02, 1'b1, 1'b0);
      channel = 4'd0;

      // Reset mid-message.
      send3(8'h90, 8'h3C, 8'h64);
      send(8'h90); send(8'h3C);
      @(posedge clk);
      #2 rst_n = 1'b0;
      expect_out("async reset", 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      send(8'h64);
      expect_out("data after reset", 8'h00, 8'h00, 1'b0, 1'b0);
      send3(8'h90, 8'h30, 8'h01);
      expect_out("note after reset", 8'h30, 8'h02, 1'b1, 1'b1);

      repeat (2) @(negedge clk);
      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/midi_voice_controller.md
MIDI_VOICE_CONTROLLER -- requirements
Module: midi_voice_controller

Interface
REQ-001 Parameter: OMNI, default 0, 1 = accept messages on all channels, 0 = accept only channel equal to input channel.
REQ-002 Parameter: AMPLITUDE_BITS, default 8, width of amplitude output.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: rx_data  input  8  received MIDI byte.
REQ-006 Port: rx_valid  input  1  one-cycle strobe; rx_data sampled when high.
REQ-007 Port: channel  input  4  MIDI channel to listen on (ignored when OMNI=1).
REQ-008 Port: midi_data  output  8  current note number, bit 7 always 0; drives voice note input.
REQ-009 Port: amplitude  output  AMPLITUDE_BITS  current note velocity, scaled.
REQ-010 Port: enable  output  1  gate; high while a note is held.
REQ-011 Port: note_event  output  1  one-cycle pulse when midi_data/amplitude/enable change due to a message.

Function
REQ-012 Byte class: bit7=1 status; 0x80-0xEF channel voice; 0xF0-0xF7 system common; 0xF8-0xFF realtime; bit7=0 data.
REQ-013 FSM states: IDLE (no running status), WAIT_D1, WAIT_D2; transitions only on cycles with rx_valid=1.
REQ-014 Channel voice status: store status as running status, go WAIT_D1, from any state (aborts partial message, no output change).
REQ-015 System common status: clear running status, go IDLE, from any state.
REQ-016 Realtime status: no effect on state, running status or outputs.
REQ-017 Data byte in IDLE: discarded.
REQ-018 Data byte in WAIT_D1: store as d1; if running status is 0xC_/0xD_ (one data byte) return to WAIT_D1, else go WAIT_D2.
REQ-019 Data byte in WAIT_D2: complete message with d1/d2, execute per REQ-020..023, return to WAIT_D1 (running status retained).
REQ-020 Channel mismatch (OMNI=0, status low nibble != channel): message consumed, no output change.
REQ-021 Note-on (0x9n) with d2!=0: midi_data<=d1, amplitude<=velocity scaled, enable<=1 (last-note priority; retrigger allowed).
REQ-022 Note-off (0x8n), or note-on with d2=0: if d1==midi_data and enable=1, enable<=0; midi_data and amplitude hold; else no change.
REQ-023 Control change 0xBn with d1=123 (all notes off): enable<=0; all other control, pitch-bend, aftertouch, program messages: no output change.
REQ-024 Scaling: amplitude = {d2[6:0], d2[6]} for AMPLITUDE_BITS=8 (127->255, 64->129, 1->2); general width: d2 left-justified, MSBs replicated into LSBs.
REQ-025 Latency: outputs and note_event update on the clock edge that samples the final data byte; visible next cycle.
REQ-026 note_event pulses exactly one cycle, only when REQ-021, REQ-022 (matching) or REQ-023 (enable was 1) changes an output.
REQ-027 rx_valid=0: state and outputs hold; no rx_ready back-pressure; one byte accepted per cycle at full rate.
REQ-028 Changing channel input mid-message: evaluated at message completion only.

Reset
REQ-029 rst_n=0 asynchronously forces state IDLE, running status cleared, midi_data=0, amplitude=0, enable=0, note_event=0.
REQ-030 Reset mid-message discards partial message; first data byte after release is discarded until a status byte arrives.
REQ-031 Leaving reset requires no extra cycles; first rx_valid after rst_n high is processed.

Verification
REQ-032 Channel 0, bytes 0x90,0x3C,0x64 -> midi_data=0x3C, amplitude=0xC9, enable=1, single note_event pulse one cycle after third byte.
REQ-033 Running status: 0x90,0x3C,0x64 then 0x40,0x7F -> midi_data=0x40, amplitude=0xFF, enable=1; then 0x3C,0x00 -> no change, no note_event; 0x40,0x00 -> enable=0.
REQ-034 Realtime interleave: 0x90,0xF8,0x3C,0xFE,0x64 -> same result as REQ-032; 0xF0 between bytes -> message aborted, no output change.
REQ-035 Channel filter: OMNI=0, channel=2, 0x91,0x3C,0x64 -> no change; 0x92,0x3C,0x64 -> enable=1; 0xB2,0x7B,0x00 -> enable=0 with note_event.
REQ-036 Reset: assert rst_n after 0x90,0x3C -> all outputs 0; release, send 0x64 -> ignored; send 0x90,0x30,0x01 -> midi_data=0x30, amplitude=0x02, enable=1.
